// File: rtl/video_scaler_timing.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_scaler_timing: VGA timing with centred, integer-scaled FB readout    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module video_scaler_timing #(
    parameter int H       = 640,
    parameter int HFP     = 16,
    parameter int HS      = 96,
    parameter int HBP     = 48,
    parameter int V       = 400,
    parameter int VFP     = 12,
    parameter int VS      = 2,
    parameter int VBP     = 35,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b1,
    parameter int SRC_W   = 96,
    parameter int SRC_H   = 64,
    parameter int SCALE_X = 4,
    parameter int SCALE_Y = 4,
    parameter int ADDR_W  = 16,
    parameter int FB_BASE = 0
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [7:0]        border_color,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_rd,
    input  logic [7:0]        fb_data,
    output logic              hs,
    output logic              vs,
    output logic              de,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              frame_start
);

    localparam int HT    = H + HFP + HS + HBP;
    localparam int VT    = V + VFP + VS + VBP;
    localparam int HW    = $clog2(HT);
    localparam int VW    = $clog2(VT);
    localparam int WIN_W = SRC_W * SCALE_X;
    localparam int WIN_H = SRC_H * SCALE_Y;
    localparam int X_OFF = (H - WIN_W) / 2;
    localparam int Y_OFF = (V - WIN_H) / 2;
    localparam int SXW   = $clog2(SCALE_X + 1);
    localparam int SYW   = $clog2(SCALE_Y + 1);
    localparam int SRCXW = $clog2(SRC_W + 1);

    localparam logic [1:0] MODE_TEST   = 2'd0;
    localparam logic [1:0] MODE_RGB    = 2'd1;
    localparam logic [1:0] MODE_MONO   = 2'd2;
    localparam logic [1:0] MODE_BORDER = 2'd3;

    if (H < WIN_W) begin : g_chk_x
        $error("scaled source wider than visible area");
    end
    if (V < WIN_H) begin : g_chk_y
        $error("scaled source taller than visible area");
    end

    // ---------------- stage 0: counters, window tracking, read address -------
    logic [HW-1:0]     h_cnt_q, h_cnt_d;
    logic [VW-1:0]     v_cnt_q, v_cnt_d;
    logic              hwin_q, hwin_d;
    logic              vwin_q, vwin_d;
    logic [SXW-1:0]    sx_q, sx_d;
    logic [SYW-1:0]    sy_q, sy_d;
    logic [SRCXW-1:0]  src_x_q, src_x_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic              fb_rd_q, fb_rd_d;
    logic [1:0]        mode_q, mode_d;
    logic [7:0]        border_q, border_d;

    logic              w_line_end;
    logic              w_v_step;
    logic              w_frame_wrap;
    logic [ADDR_W-1:0] w_pix_idx;

    always_comb begin
        w_line_end   = (h_cnt_q == HW'(HT - 1));
        w_v_step     = (h_cnt_q == HW'(H + HFP));
        w_frame_wrap = w_v_step && (v_cnt_q == VW'(VT - 1));

        h_cnt_d = w_line_end ? '0 : h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (w_v_step) begin
            v_cnt_d = w_frame_wrap ? '0 : v_cnt_q + VW'(1);
        end

        // Mode and border only change between frames so a frame is never mixed.
        mode_d   = mode_q;
        border_d = border_q;
        if (w_frame_wrap) begin
            mode_d   = mode;
            border_d = border_color;
        end

        hwin_d = (h_cnt_d >= HW'(X_OFF)) && (h_cnt_d < HW'(X_OFF + WIN_W));
        vwin_d = (v_cnt_d >= VW'(Y_OFF)) && (v_cnt_d < VW'(Y_OFF + WIN_H));

        sx_d    = sx_q;
        src_x_d = src_x_q;
        if (h_cnt_d == HW'(X_OFF)) begin
            sx_d    = '0;
            src_x_d = '0;
        end else if (hwin_q) begin
            if (sx_q == SXW'(SCALE_X - 1)) begin
                sx_d    = '0;
                src_x_d = src_x_q + SRCXW'(1);
            end else begin
                sx_d = sx_q + SXW'(1);
            end
        end

        // Row base advances by one source line each time SCALE_Y lines are done.
        sy_d        = sy_q;
        line_base_d = line_base_q;
        if (w_frame_wrap) begin
            sy_d        = '0;
            line_base_d = '0;
        end else if (w_v_step && vwin_q) begin
            if (sy_q == SYW'(SCALE_Y - 1)) begin
                sy_d        = '0;
                line_base_d = line_base_q + ADDR_W'(SRC_W);
            end else begin
                sy_d = sy_q + SYW'(1);
            end
        end

        w_pix_idx = line_base_d + ADDR_W'(src_x_d);
        fb_rd_d   = hwin_d && vwin_d && ((mode_d == MODE_RGB) || (mode_d == MODE_MONO));
        fb_addr_d = fb_addr_q;
        if (fb_rd_d) begin
            fb_addr_d = (mode_d == MODE_RGB) ? ADDR_W'(FB_BASE) + w_pix_idx
                                             : ADDR_W'(FB_BASE) + (w_pix_idx >> 3);
        end
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            hwin_q      <= (X_OFF == 0);
            vwin_q      <= (Y_OFF == 0);
            sx_q        <= '0;
            sy_q        <= '0;
            src_x_q     <= '0;
            line_base_q <= '0;
            fb_addr_q   <= '0;
            fb_rd_q     <= 1'b0;
            mode_q      <= MODE_TEST;
            border_q    <= 8'h00;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            hwin_q      <= hwin_d;
            vwin_q      <= vwin_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            src_x_q     <= src_x_d;
            line_base_q <= line_base_d;
            fb_addr_q   <= fb_addr_d;
            fb_rd_q     <= fb_rd_d;
            mode_q      <= mode_d;
            border_q    <= border_d;
        end
    end

    assign fb_addr = fb_addr_q;
    assign fb_rd   = fb_rd_q;

    // ---------------- stage 1: carry position info while fb_data returns -----
    logic       s1_de_q, s1_de_d;
    logic       s1_hs_q, s1_hs_d;
    logic       s1_vs_q, s1_vs_d;
    logic       s1_fs_q, s1_fs_d;
    logic       s1_win_q, s1_win_d;
    logic       s1_chk_q, s1_chk_d;
    logic [2:0] s1_bit_q, s1_bit_d;
    logic [1:0] s1_mode_q, s1_mode_d;
    logic [7:0] s1_border_q, s1_border_d;

    always_comb begin
        s1_de_d     = (h_cnt_q < HW'(H)) && (v_cnt_q < VW'(V));
        s1_hs_d     = ((h_cnt_q >= HW'(H + HFP)) && (h_cnt_q < HW'(H + HFP + HS)))
                      ? HS_POL : ~HS_POL;
        s1_vs_d     = ((v_cnt_q >= VW'(V + VFP)) && (v_cnt_q < VW'(V + VFP + VS)))
                      ? VS_POL : ~VS_POL;
        s1_fs_d     = (h_cnt_q == '0) && (v_cnt_q == '0);
        s1_win_d    = hwin_q && vwin_q;
        s1_chk_d    = v_cnt_q[2] ^ h_cnt_q[2];
        s1_bit_d    = src_x_q[2:0];
        s1_mode_d   = mode_q;
        s1_border_d = border_q;
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            s1_de_q     <= 1'b0;
            s1_hs_q     <= ~HS_POL;
            s1_vs_q     <= ~VS_POL;
            s1_fs_q     <= 1'b0;
            s1_win_q    <= 1'b0;
            s1_chk_q    <= 1'b0;
            s1_bit_q    <= '0;
            s1_mode_q   <= MODE_TEST;
            s1_border_q <= 8'h00;
        end else begin
            s1_de_q     <= s1_de_d;
            s1_hs_q     <= s1_hs_d;
            s1_vs_q     <= s1_vs_d;
            s1_fs_q     <= s1_fs_d;
            s1_win_q    <= s1_win_d;
            s1_chk_q    <= s1_chk_d;
            s1_bit_q    <= s1_bit_d;
            s1_mode_q   <= s1_mode_d;
            s1_border_q <= s1_border_d;
        end
    end

    // ---------------- stage 2: pixel select, RGB332 expansion, outputs -------
    logic [7:0] w_pix;
    logic [7:0] r_q, r_d;
    logic [7:0] g_q, g_d;
    logic [7:0] b_q, b_d;
    logic       hs_q, vs_q, de_q, fs_q;

    always_comb begin
        w_pix = s1_border_q;
        if (s1_win_q) begin
            case (s1_mode_q)
                MODE_TEST:   w_pix = s1_chk_q ? 8'h00 : 8'hFF;
                MODE_RGB:    w_pix = fb_data;
                MODE_MONO:   w_pix = fb_data[s1_bit_q] ? 8'h00 : 8'hFF;
                MODE_BORDER: w_pix = s1_border_q;
                default:     w_pix = s1_border_q;
            endcase
        end
        if (!s1_de_q) begin
            w_pix = 8'h00;
        end
        r_d = {w_pix[7:5], w_pix[7:5], w_pix[7:6]};
        g_d = {w_pix[4:2], w_pix[4:2], w_pix[4:3]};
        b_d = {4{w_pix[1:0]}};
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            r_q  <= 8'h00;
            g_q  <= 8'h00;
            b_q  <= 8'h00;
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
            de_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
            hs_q <= s1_hs_q;
            vs_q <= s1_vs_q;
            de_q <= s1_de_q;
            fs_q <= s1_fs_q;
        end
    end

    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign frame_start = fs_q;

endmodule
`default_nettype wire
